oled_pixel_scan: RTL and testbench
==================================

// Module: oled_pixel_scan
// PURPOSE
//  Upstream stage of the per-pixel colour generators. Converts the OLED driver's
//  frame_begin / sample_pixel / pixel_index stream into registered (x,y)
//  coordinates using row/column counters instead of a divider.
//  Also produces the frame-synchronous 'active' blink flag that the colour
//  generators use to alternate their background colour.
// PARAMETERS
//  WIDTH        96  pixels per row; x range 0..WIDTH-1
//  HEIGHT       64  rows per frame; y range 0..HEIGHT-1
//  BLINK_FRAMES 30  frames between toggles of active; legal range 1..65535
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  frame_begin  in   1   one-cycle pulse from the OLED driver at the start of each frame
//  sample_pixel in   1   one-cycle pulse: the driver fetches pixel_index this cycle
//  pixel_index  in   13  linear index of the fetched pixel, 0..6143
//  blink_en     in   1   1 = active toggles; 0 = active held at 0
//  x            out  7   column of the last sampled pixel
//  y            out  6   row of the last sampled pixel
//  coord_valid  out  1   x,y correspond to an accepted sample in the current frame
//  active       out  1   blink flag; changes only on frame_begin
//  frame_count  out  16  frames started since reset; wraps 0xFFFF->0
//  resync       out  1   one-cycle pulse: index mismatch detected
// BEHAVIOUR
//  Reset: x=0, y=0, coord_valid=0, active=0, frame_count=0, resync=0.
//   Internal state: IDLE, col=row=0, blink_cnt=0.
//  FSM IDLE -> SCAN on frame_begin. SCAN -> HOLD after accepting pixel (WIDTH-1,HEIGHT-1).
//   HOLD -> SCAN on frame_begin. Any state -> SCAN on frame_begin.
//  frame_begin: col=row=0, coord_valid=0, frame_count+=1.
//  sample_pixel in SCAN: one cycle later, x=col, y=row, coord_valid=1.
//   col increments; at WIDTH-1, col=0 and row increments.
//  sample_pixel in IDLE or HOLD: ignored; outputs hold.
//  frame_begin and sample_pixel in the same cycle: frame_begin applies first.
//   The sample is accepted as pixel (0,0); col becomes 1.
//  Blink, on frame_begin with blink_en=1:
//   blink_cnt==BLINK_FRAMES-1 -> blink_cnt=0 and active toggles.
//   Otherwise blink_cnt increments.
//  blink_en=0: active=0 and blink_cnt=0 on the next clk, independent of frames.
//  Reset asserted mid-frame clears all state immediately. The first frame_begin after release restarts the scan.
// CONFIGURATION
//  COORD_CHECK_EN defined:
//   Each accepted sample compares pixel_index with row*WIDTH+col. The expected index is
//   an incrementally maintained 13-bit counter (no multiplier).
//   On mismatch: resync=1 for one cycle, coord_valid=0, FSM -> IDLE until the next frame_begin.
//   A sample_pixel in HOLD also raises resync.
//  COORD_CHECK_EN undefined: no compare, resync tied 0, counters trust sample_pixel.
// STRUCTURE
//  oled_pkg:
//   WIDTH/HEIGHT defaults, PIXELS=6144, colour constants shared with the colour generators,
//   scan state encoding (IDLE=2'd0, SCAN=2'd1, HOLD=2'd2).
//  Sub-module blink_timer: blink_cnt and the active toggle, driven by frame_begin and blink_en.
// TESTING
//  1. Reset, frame_begin, 6144 samples with pixel_index 0..6143:
//     sample 0 -> (0,0); 95 -> (95,0); 96 -> (0,1); 6143 -> (95,63).
//     FSM in HOLD, coord_valid=1.
//  2. Extra sample_pixel after 6143: x,y hold. resync=1 only with COORD_CHECK_EN.
//  3. frame_begin and sample_pixel in the same cycle at pixel 4000:
//     next cycle x=0, y=0, frame_count+1.
//  4. blink_en=1, BLINK_FRAMES=2, 6 frame_begins: active 0->1->0->1, toggling on frames 2, 4, 6.
//     Drop blink_en -> active=0 the next cycle.
//  5. COORD_CHECK_EN, sample with pixel_index=7 when 5 is expected:
//     resync pulse, coord_valid=0, later samples ignored until frame_begin.
//  6. Assert reset mid-frame (sample 300): all outputs reset asynchronously.
//     Samples before the next frame_begin are ignored.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants for the OLED pixel pipeline: panel geometry, RGB565 colours
// and the scan FSM encoding.
package oled_pkg;

    localparam int unsigned OLED_WIDTH  = 96;
    localparam int unsigned OLED_HEIGHT = 64;
    localparam int unsigned PIXELS      = OLED_WIDTH * OLED_HEIGHT;

    localparam logic [15:0] COLOUR_BLACK  = 16'h0000;
    localparam logic [15:0] COLOUR_WHITE  = 16'hFFFF;
    localparam logic [15:0] COLOUR_RED    = 16'hF800;
    localparam logic [15:0] COLOUR_GREEN  = 16'h07E0;
    localparam logic [15:0] COLOUR_BLUE   = 16'h001F;
    localparam logic [15:0] COLOUR_YELLOW = 16'hFFE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } scan_state_e;

endpackage

// File: rtl/oled_pixel_scan_blink_timer.sv
// Frame-synchronous blink flag: toggles every BLINK_FRAMES frame starts while
// blink_en is high, forced low (and the frame count cleared) otherwise.
module blink_timer
    import oled_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_begin,
    input  logic blink_en,
    output logic active
);

    localparam logic [15:0] CNT_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (!blink_en) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (frame_begin) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                active_d = ~active_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/oled_pixel_scan.sv
// Converts the OLED driver's frame/sample stream into registered (x,y) via
// row/column counters. Optional index cross-check under `COORD_CHECK_EN.
module oled_pixel_scan
    import oled_pkg::*;
#(
    parameter int unsigned WIDTH        = OLED_WIDTH,
    parameter int unsigned HEIGHT       = OLED_HEIGHT,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic        sample_pixel,
    input  logic [12:0] pixel_index,
    input  logic        blink_en,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        coord_valid,
    output logic        active,
    output logic [15:0] frame_count,
    output logic        resync
);

    localparam logic [6:0] COL_LAST = 7'(WIDTH - 1);
    localparam logic [5:0] ROW_LAST = 6'(HEIGHT - 1);

    scan_state_e state_q, state_d;
    logic [6:0]  col_q, col_d, x_q, x_d;
    logic [5:0]  row_q, row_d, y_q, y_d;
    logic        valid_q, valid_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        resync_q, resync_d;

    // frame_begin takes effect before a coincident sample, so the sample sees
    // freshly cleared counters.
    logic [6:0] cur_col;
    logic [5:0] cur_row;
    logic       scanning;
    logic       mismatch, hold_hit, accept;

    assign cur_col  = frame_begin ? '0 : col_q;
    assign cur_row  = frame_begin ? '0 : row_q;
    assign scanning = frame_begin || (state_q == ST_SCAN);

`ifdef COORD_CHECK_EN
    logic [12:0] idx_q, idx_d, cur_idx;

    assign cur_idx  = frame_begin ? '0 : idx_q;
    assign mismatch = sample_pixel && scanning && (pixel_index != cur_idx);
    assign hold_hit = sample_pixel && !frame_begin && (state_q == ST_HOLD);
    assign idx_d    = accept ? cur_idx + 13'd1 : cur_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end
`else
    logic unused_pixel_index;

    assign unused_pixel_index = ^pixel_index;
    assign mismatch           = 1'b0;
    assign hold_hit           = 1'b0;
`endif

    assign accept = sample_pixel && scanning && !mismatch;

    always_comb begin
        state_d  = state_q;
        col_d    = cur_col;
        row_d    = cur_row;
        x_d      = x_q;
        y_d      = y_q;
        valid_d  = valid_q;
        fcnt_d   = fcnt_q;
        resync_d = mismatch | hold_hit;

        if (frame_begin) begin
            state_d = ST_SCAN;
            valid_d = 1'b0;
            fcnt_d  = fcnt_q + 16'd1;
        end

        if (mismatch) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end

        if (accept) begin
            x_d     = cur_col;
            y_d     = cur_row;
            valid_d = 1'b1;
            if (cur_col == COL_LAST) begin
                col_d = '0;
                if (cur_row == ROW_LAST) begin
                    row_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    row_d = cur_row + 6'd1;
                end
            end else begin
                col_d = cur_col + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            fcnt_q   <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            fcnt_q   <= fcnt_d;
            resync_q <= resync_d;
        end
    end

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .frame_begin (frame_begin),
        .blink_en    (blink_en),
        .active      (active)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign coord_valid = valid_q;
    assign frame_count = fcnt_q;
    assign resync      = resync_q;

endmodule

// File: tb/tb_oled_pixel_scan.sv
// Self-checking bench for oled_pixel_scan against a sample-count reference model.
module tb_oled_pixel_scan;

    localparam int W    = 96;
    localparam int H    = 64;
    localparam int NPIX = W * H;
    localparam int BF   = 2;
`ifdef COORD_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_begin = 1'b0;
    logic        sample_pixel = 1'b0;
    logic [12:0] pixel_index = '0;
    logic        blink_en = 1'b0;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        coord_valid;
    logic        active;
    logic [15:0] frame_count;
    logic        resync;

    oled_pixel_scan #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_begin  (frame_begin),
        .sample_pixel (sample_pixel),
        .pixel_index  (pixel_index),
        .blink_en     (blink_en),
        .x            (x),
        .y            (y),
        .coord_valid  (coord_valid),
        .active       (active),
        .frame_count  (frame_count),
        .resync       (resync)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pixels accepted this frame (m_n) gives x = n%W, y = n/W.
    int m_fc, m_n, m_x, m_y, m_en_frames;
    bit m_in, m_valid, m_resync;
    bit exp_act [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    function automatic bit m_active();
        return ((m_en_frames / BF) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_fc = 0; m_n = 0; m_x = 0; m_y = 0; m_en_frames = 0;
        m_in = 1'b0; m_valid = 1'b0; m_resync = 1'b0;
    endtask

    // Entered and left at posedge+1.
    task automatic cyc(input bit fb, input bit sp, input int idx);
        bit ben;
        frame_begin  = fb;
        sample_pixel = sp;
        pixel_index  = 13'(idx);
        ben          = blink_en;
        @(posedge clk); #1;
        frame_begin  = 1'b0;
        sample_pixel = 1'b0;
        m_resync = 1'b0;
        if (!ben) m_en_frames = 0;
        if (fb) begin
            m_fc++; m_in = 1'b1; m_n = 0; m_valid = 1'b0;
            if (ben) m_en_frames++;
        end
        if (sp) begin
            if (m_in && m_n < NPIX) begin
                if (CHECK && idx != m_n) begin
                    m_resync = 1'b1; m_valid = 1'b0; m_in = 1'b0;
                end else begin
                    m_x = m_n % W; m_y = m_n / W; m_valid = 1'b1; m_n++;
                end
            end else if (CHECK && m_in) begin
                m_resync = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (x !== 7'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", x); end
        total++; if (y !== 6'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", y); end
        total++; if (coord_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", coord_valid); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_fc: got %0d want 0", frame_count); end
        total++; if (resync !== 1'b0) begin bad++; $display("FAIL reset_resync: got %b want 0", resync); end
        reset = 1'b0;
        cyc(0, 0, 0);
    endtask

    task automatic test_full_frame();
        int ex, ey;
        cyc(1, 0, 0);
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(0, 0, 0);
            cyc(0, 1, i);
            total++; if (x !== 7'(m_x)) begin bad++; $display("FAIL full_x i=%0d: got %0d want %0d", i, x, m_x); end
            total++; if (y !== 6'(m_y)) begin bad++; $display("FAIL full_y i=%0d: got %0d want %0d", i, y, m_y); end
            total++; if (coord_valid !== m_valid) begin bad++; $display("FAIL full_valid i=%0d: got %b want %b", i, coord_valid, m_valid); end
            total++; if (resync !== 1'b0) begin bad++; $display("FAIL full_resync i=%0d: got %b want 0", i, resync); end
            if (i == 0 || i == 95 || i == 96 || i == NPIX - 1) begin
                case (i)
                    0:       begin ex = 0;  ey = 0;  end
                    95:      begin ex = 95; ey = 0;  end
                    96:      begin ex = 0;  ey = 1;  end
                    default: begin ex = 95; ey = 63; end
                endcase
                total++; if (x !== 7'(ex) || y !== 6'(ey)) begin
                    bad++; $display("FAIL spot_xy i=%0d: got (%0d,%0d) want (%0d,%0d)", i, x, y, ex, ey);
                end
            end
        end
        total++; if (frame_count !== 16'(m_fc)) begin bad++; $display("FAIL full_fc: got %0d want %0d", frame_count, m_fc); end
    endtask

    task automatic test_extra_sample();
        cyc(0, 1, NPIX);
        total++; if (x !== 7'd95 || y !== 6'd63) begin bad++; $display("FAIL extra_xy: got (%0d,%0d) want (95,63)", x, y); end
        total++; if (coord_valid !== 1'b1) begin bad++; $display("FAIL extra_valid: got %b want 1", coord_valid); end
        total++; if (resync !== m_resync) begin bad++; $display("FAIL extra_resync: got %b want %b", resync, m_resync); end
        cyc(0, 0, 0);
        total++; if (resync !== 1'b0) begin bad++; $display("FAIL extra_resync_clear: got %b want 0", resync); end
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 0);
        for (int i = 0; i < 4000; i++) cyc(0, 1, i);
        total++; if (x !== 7'(3999 % W) || y !== 6'(3999 / W)) begin
            bad++; $display("FAIL pre_same_xy: got (%0d,%0d) want (%0d,%0d)", x, y, 3999 % W, 3999 / W);
        end
        cyc(1, 1, 0);
        total++; if (x !== 7'd0 || y !== 6'd0) begin bad++; $display("FAIL same_xy: got (%0d,%0d) want (0,0)", x, y); end
        total++; if (coord_valid !== 1'b1) begin bad++; $display("FAIL same_valid: got %b want 1", coord_valid); end
        total++; if (frame_count !== 16'(m_fc)) begin bad++; $display("FAIL same_fc: got %0d want %0d", frame_count, m_fc); end
        cyc(0, 1, 1);
        total++; if (x !== 7'd1 || y !== 6'd0) begin bad++; $display("FAIL same_next_xy: got (%0d,%0d) want (1,0)", x, y); end
    endtask

    task automatic test_blink();
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            cyc(1, 0, 0);
            total++; if (active !== exp_act[f]) begin bad++; $display("FAIL blink_f%0d: got %b want %b", f + 1, active, exp_act[f]); end
            for (int k = 0; k < 3; k++) begin
                cyc(0, 0, 0);
                total++; if (active !== m_active()) begin bad++; $display("FAIL blink_hold_f%0d: got %b want %b", f + 1, active, m_active()); end
            end
        end
        blink_en = 1'b0;
        cyc(0, 0, 0);
        total++; if (active !== 1'b0) begin bad++; $display("FAIL blink_drop: got %b want 0", active); end
    endtask

    task automatic test_mismatch();
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, i);
        cyc(0, 1, 7);
        total++; if (resync !== m_resync) begin bad++; $display("FAIL mm_resync: got %b want %b", resync, m_resync); end
        total++; if (coord_valid !== m_valid) begin bad++; $display("FAIL mm_valid: got %b want %b", coord_valid, m_valid); end
        total++; if (x !== 7'(CHECK ? 4 : 5)) begin bad++; $display("FAIL mm_x: got %0d want %0d", x, CHECK ? 4 : 5); end
        cyc(0, 1, 5);
        total++; if (resync !== 1'b0) begin bad++; $display("FAIL mm_pulse: got %b want 0", resync); end
        total++; if (x !== 7'(m_x) || coord_valid !== m_valid) begin
            bad++; $display("FAIL mm_after: got x=%0d v=%b want x=%0d v=%b", x, coord_valid, m_x, m_valid);
        end
        cyc(1, 1, 0);
        total++; if (coord_valid !== 1'b1 || x !== 7'd0) begin
            bad++; $display("FAIL mm_restart: got x=%0d v=%b want x=0 v=1", x, coord_valid);
        end
    endtask

    task automatic test_reset_midframe();
        cyc(1, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, i);
        #3 reset = 1'b1;
        #1;
        total++; if (x !== 7'd0 || y !== 6'd0) begin bad++; $display("FAIL mid_xy: got (%0d,%0d) want (0,0)", x, y); end
        total++; if (coord_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", coord_valid); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL mid_fc: got %0d want 0", frame_count); end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, i);
            total++; if (coord_valid !== 1'b0 || x !== 7'd0) begin
                bad++; $display("FAIL mid_ignore%0d: got x=%0d v=%b want x=0 v=0", i, x, coord_valid);
            end
        end
        cyc(1, 1, 0);
        total++; if (coord_valid !== 1'b1 || frame_count !== 16'd1) begin
            bad++; $display("FAIL mid_restart: got v=%b fc=%0d want v=1 fc=1", coord_valid, frame_count);
        end
    endtask

    task automatic test_random();
        bit fb, sp;
        int idx;
        blink_en = 1'b1;
        cyc(1, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) blink_en = ~blink_en;
            fb  = ($urandom_range(0, 299) == 0);
            sp  = ($urandom_range(0, 3) != 0);
            idx = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 8191)) : m_n;
            cyc(fb, sp, idx);
            total++; if (x !== 7'(m_x) || y !== 6'(m_y)) begin
                bad++; $display("FAIL rnd_xy c=%0d: got (%0d,%0d) want (%0d,%0d)", c, x, y, m_x, m_y);
            end
            total++; if (coord_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, coord_valid, m_valid); end
            total++; if (resync !== m_resync) begin bad++; $display("FAIL rnd_resync c=%0d: got %b want %b", c, resync, m_resync); end
            total++; if (active !== m_active()) begin bad++; $display("FAIL rnd_active c=%0d: got %b want %b", c, active, m_active()); end
            total++; if (frame_count !== 16'(m_fc)) begin bad++; $display("FAIL rnd_fc c=%0d: got %0d want %0d", c, frame_count, m_fc); end
        end
        blink_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_extra_sample();
        test_same_cycle();
        test_blink();
        test_mismatch();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
